// File: rtl/ula_pkg.sv
// Shared types and 7-segment constants for the ALU result display.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CONVERT,
    SHOW
  } state_e;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_O     = 7'b0100011;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/ula_display_if.sv
// Result handshake from the ALU into the display stage.
interface ula_display_if #(
  parameter int DATA_W = 6
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic              in_overflow;
  logic              in_signed;

  modport master (
    output in_valid, in_result, in_zero, in_overflow, in_signed,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_result, in_zero, in_overflow, in_signed,
    output in_ready
  );

endinterface

// File: rtl/ula_display_seg7.sv
// One 7-segment digit: BCD digit, minus sign, or blank (blank wins).
module seg7_decoder
  import ula_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] seg
);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      if (minus) begin
        seg = SEG_MINUS;
      end else if (digit <= 4'd9) begin
        seg = SEG_DIGITS[digit];
      end
    end
  end

endmodule

// File: rtl/ula_display.sv
// ALU output stage: serial shift-add-3 binary-to-BCD conversion driving
// sign/tens/ones digits, a blinking overflow indicator and flag LEDs.
module ula_display
  import ula_pkg::*;
#(
  parameter int DATA_W    = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  ula_display_if.slave  alu,
  output logic [6:0]    HEX0,
  output logic [6:0]    HEX1,
  output logic [6:0]    HEX2,
  output logic [6:0]    HEX3,
  output logic          zero_led,
  output logic          ovf_led,
  output logic          done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              ovf_q, ovf_d;
  logic              signed_q, signed_d;
  logic              neg_q, neg_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [7:0]        bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              fresh_q, fresh_d;
  logic [6:0]        hex0_q, hex0_d;
  logic [6:0]        hex1_q, hex1_d;
  logic [6:0]        hex2_q, hex2_d;
  logic              zero_led_q, zero_led_d;
  logic              ovf_led_q, ovf_led_d;
  logic              done_q, done_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;

  logic [7:0]        adj;
  logic              show_update;
  logic [6:0]        seg_ones, seg_tens, seg_sign;

  seg7_decoder u_ones (.digit(bcd_q[3:0]), .blank(1'b0),                .minus(1'b0), .seg(seg_ones));
  seg7_decoder u_tens (.digit(bcd_q[7:4]), .blank(bcd_q[7:4] == 4'd0), .minus(1'b0), .seg(seg_tens));
  seg7_decoder u_sign (.digit(4'd0),       .blank(!neg_q),              .minus(1'b1), .seg(seg_sign));

  assign alu.in_ready = (state_q == IDLE) || (state_q == SHOW);

  // fresh_q marks the first SHOW cycle, whose closing edge publishes the new result.
  assign show_update = (state_q == SHOW) && fresh_q;

  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    zero_d        = zero_q;
    ovf_d         = ovf_q;
    signed_d      = signed_q;
    neg_d         = neg_q;
    mag_d         = mag_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    fresh_d       = fresh_q;
    hex0_d        = hex0_q;
    hex1_d        = hex1_q;
    hex2_d        = hex2_q;
    zero_led_d    = zero_led_q;
    ovf_led_d     = ovf_led_q;
    done_d        = 1'b0;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    adj           = bcd_q;

    case (state_q)
      IDLE, SHOW: begin
        if (show_update) begin
          hex0_d     = seg_ones;
          hex1_d     = seg_tens;
          hex2_d     = seg_sign;
          zero_led_d = zero_q;
          ovf_led_d  = ovf_q;
          done_d     = 1'b1;
          fresh_d    = 1'b0;
        end
        if (alu.in_valid) begin
          result_d = alu.in_result;
          zero_d   = alu.in_zero;
          ovf_d    = alu.in_overflow;
          signed_d = alu.in_signed;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        neg_d   = signed_q && result_q[DATA_W-1];
        mag_d   = neg_d ? (~result_q + 1'b1) : result_q;
        bcd_d   = 8'd0;
        cnt_d   = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        {bcd_d, mag_d} = {adj, mag_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = SHOW;
          fresh_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Blink phase restarts visible on every publish and only runs while the LED is lit.
    if (show_update) begin
      blink_cnt_d   = '0;
      blink_phase_d = ovf_q;
    end else if (ovf_led_q) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      result_q      <= '0;
      zero_q        <= 1'b0;
      ovf_q         <= 1'b0;
      signed_q      <= 1'b0;
      neg_q         <= 1'b0;
      mag_q         <= '0;
      bcd_q         <= 8'd0;
      cnt_q         <= '0;
      fresh_q       <= 1'b0;
      hex0_q        <= SEG_BLANK;
      hex1_q        <= SEG_BLANK;
      hex2_q        <= SEG_BLANK;
      zero_led_q    <= 1'b0;
      ovf_led_q     <= 1'b0;
      done_q        <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      zero_q        <= zero_d;
      ovf_q         <= ovf_d;
      signed_q      <= signed_d;
      neg_q         <= neg_d;
      mag_q         <= mag_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      fresh_q       <= fresh_d;
      hex0_q        <= hex0_d;
      hex1_q        <= hex1_d;
      hex2_q        <= hex2_d;
      zero_led_q    <= zero_led_d;
      ovf_led_q     <= ovf_led_d;
      done_q        <= done_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign HEX0     = hex0_q;
  assign HEX1     = hex1_q;
  assign HEX2     = hex2_q;
  assign HEX3     = (ovf_led_q && blink_phase_q) ? SEG_O : SEG_BLANK;
  assign zero_led = zero_led_q;
  assign ovf_led  = ovf_led_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ula_display.sv
// Self-checking bench for ula_display: vector table, random results against
// a decimal reference model, and hand-written multi-cycle corner cases.
module tb_ula_display;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;
  localparam logic [6:0] OCHAR = 7'b0100011;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;
  logic       zero_led, ovf_led, done;

  int tests = 0;
  int fails = 0;

  ula_display_if #(.DATA_W(6)) alu_if ();

  ula_display #(.DATA_W(6), .BLINK_DIV(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .alu      (alu_if.slave),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .zero_led (zero_led),
    .ovf_led  (ovf_led),
    .done     (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [5:0] res;
    bit         z, o, s;
    logic [6:0] e1, e0, e2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  // Decimal reference: value -> sign, magnitude, tens/ones with leading-zero blanking.
  task automatic model(input logic [5:0] r, input bit s,
                       output logic [6:0] e1, output logic [6:0] e0, output logic [6:0] e2);
    int v, m;
    v = int'(r);
    if (s && v >= 32) v = v - 64;
    m  = (v < 0) ? -v : v;
    e0 = seg_of(m % 10);
    e1 = (m / 10 == 0) ? BLANK : seg_of(m / 10);
    e2 = (v < 0) ? MINUS : BLANK;
  endtask

  // Present one result; returns #1 after the accept edge with in_valid dropped.
  task automatic accept(input logic [5:0] r, input bit z, input bit o, input bit s);
    @(negedge CLOCK_50);
    check("ready_before_accept", alu_if.in_ready, 1'b1);
    alu_if.in_valid    = 1'b1;
    alu_if.in_result   = r;
    alu_if.in_zero     = z;
    alu_if.in_overflow = o;
    alu_if.in_signed   = s;
    @(posedge CLOCK_50);
    #1;
    alu_if.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_one(input string tag, input logic [5:0] r, input bit z, input bit o, input bit s,
                         input logic [6:0] e1, input logic [6:0] e0, input logic [6:0] e2);
    int lat;
    accept(r, z, o, s);
    wait_done(lat);
    check({tag, "_latency"}, lat, 8);
    check({tag, "_hex0"}, HEX0, e0);
    check({tag, "_hex1"}, HEX1, e1);
    check({tag, "_hex2"}, HEX2, e2);
    check({tag, "_zero_led"}, zero_led, z);
    check({tag, "_ovf_led"}, ovf_led, o);
    @(posedge CLOCK_50);
    #1;
    check({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  vec_t vecs [8];

  initial begin
    int         lat, pulses;
    logic [5:0] r;
    bit         z, o, s;
    logic [6:0] e0, e1, e2;

    vecs[0] = '{6'd45,       1'b0, 1'b0, 1'b0, 7'b0011001, 7'b0010010, BLANK};
    vecs[1] = '{6'b111011,   1'b0, 1'b0, 1'b1, BLANK,      7'b0010010, MINUS};
    vecs[2] = '{6'b100000,   1'b0, 1'b0, 1'b1, 7'b0110000, 7'b0100100, MINUS};
    vecs[3] = '{6'd0,        1'b1, 1'b0, 1'b0, BLANK,      7'b1000000, BLANK};
    vecs[4] = '{6'd63,       1'b0, 1'b0, 1'b0, 7'b0000010, 7'b0110000, BLANK};
    vecs[5] = '{6'b111111,   1'b0, 1'b0, 1'b1, BLANK,      7'b1111001, MINUS};
    vecs[6] = '{6'd10,       1'b0, 1'b0, 1'b0, 7'b1111001, 7'b1000000, BLANK};
    vecs[7] = '{6'b100000,   1'b0, 1'b0, 1'b0, 7'b0110000, 7'b0100100, BLANK};

    alu_if.in_valid    = 1'b0;
    alu_if.in_result   = '0;
    alu_if.in_zero     = 1'b0;
    alu_if.in_overflow = 1'b0;
    alu_if.in_signed   = 1'b0;

    repeat (2) @(posedge CLOCK_50);
    #1;
    check("rst_hex0", HEX0, BLANK);
    check("rst_hex1", HEX1, BLANK);
    check("rst_hex2", HEX2, BLANK);
    check("rst_hex3", HEX3, BLANK);
    check("rst_zero_led", zero_led, 1'b0);
    check("rst_ovf_led", ovf_led, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ready", alu_if.in_ready, 1'b1);
    reset = 1'b0;

    foreach (vecs[i])
      run_one($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].o, vecs[i].s,
              vecs[i].e1, vecs[i].e0, vecs[i].e2);

    for (int i = 0; i < 30; i++) begin
      r = 6'($urandom_range(0, 63));
      z = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      model(r, s, e1, e0, e2);
      run_one($sformatf("rnd%0d", i), r, z, o, s, e1, e0, e2);
    end

    // Overflow blink: 'o' for 4 cycles from the publish edge, then blank for 4, repeating.
    accept(6'd7, 1'b0, 1'b1, 1'b0);
    wait_done(lat);
    check("blink_latency", lat, 8);
    check("blink_ovf_led", ovf_led, 1'b1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("blink_hex3_c%0d", i), HEX3, ((i / 4) % 2 == 0) ? OCHAR : BLANK);
      @(posedge CLOCK_50);
      #1;
    end
    run_one("ovf_clear", 6'd9, 1'b0, 1'b0, 1'b0, BLANK, 7'b0010000, BLANK);
    repeat (5) @(posedge CLOCK_50);
    #1;
    check("ovf_clear_hex3", HEX3, BLANK);

    // in_valid pulsed during CONVERT is ignored.
    accept(6'd45, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("busy_ready_low", alu_if.in_ready, 1'b0);
    alu_if.in_valid  = 1'b1;
    alu_if.in_result = 6'd10;
    @(posedge CLOCK_50);
    #1;
    alu_if.in_valid = 1'b0;
    wait_done(lat);
    check("busy_latency", lat, 5);
    check("busy_hex0", HEX0, 7'b0010010);
    check("busy_hex1", HEX1, 7'b0011001);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (done) pulses++;
    end
    check("busy_no_second_done", pulses, 0);

    // Accept in SHOW holds the old display until the new publish edge.
    accept(6'd10, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge CLOCK_50);
    #1;
    check("hold_hex0_old", HEX0, 7'b0010010);
    check("hold_hex1_old", HEX1, 7'b0011001);
    @(posedge CLOCK_50);
    #1;
    check("hold_done_new", done, 1'b1);
    check("hold_hex0_new", HEX0, 7'b1000000);
    check("hold_hex1_new", HEX1, 7'b1111001);

    // Reset three cycles into CONVERT discards the conversion and blanks everything.
    run_one("pre_rst", 6'b111011, 1'b1, 1'b1, 1'b1, BLANK, 7'b0010010, MINUS);
    accept(6'd45, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1;
    check("mid_rst_hex0", HEX0, BLANK);
    check("mid_rst_hex1", HEX1, BLANK);
    check("mid_rst_hex2", HEX2, BLANK);
    check("mid_rst_hex3", HEX3, BLANK);
    check("mid_rst_zero_led", zero_led, 1'b0);
    check("mid_rst_ovf_led", ovf_led, 1'b0);
    check("mid_rst_ready", alu_if.in_ready, 1'b1);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (done) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);
    check("mid_rst_still_blank", HEX0, BLANK);
    run_one("post_rst", 6'd63, 1'b0, 1'b0, 1'b0, 7'b0000010, 7'b0110000, BLANK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
